tdm_demux16: RTL and testbench

- Receive-side partner to the 16-to-1 mux serializer.
- Takes a 1-bit time-division stream, one bit per enabled clock, where slot k carries in[k] of the transmitted word (slot 0 first, marked by frame_sync).
- Routes each slot bit into a shadow register and presents the reassembled 16-bit word in parallel with a one-cycle valid pulse.
- Detects framing loss.

---
 rtl/tdm_demux16_if.sv | 31 +++
 rtl/tdm_demux16.sv | 114 +++++++++++
 tb/tb_tdm_demux16.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux16_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux16_if
//  Description : Serial-in / parallel-out bus bundle for the TDM demultiplexer.
//                The master drives the slot stream and the slave returns the
//                reassembled word, its valid pulse, slot index and error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdm_demux16_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             en;
  logic             frame_sync;
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [SEL_W-1:0] slot;
  logic             sync_err;

  modport master (
    output en, frame_sync, din,
    input  dout, dout_valid, slot, sync_err
  );

  modport slave (
    input  en, frame_sync, din,
    output dout, dout_valid, slot, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux16.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux16
//  Description : 16-slot TDM receiver. One serial bit is captured per enabled
//                clock into a shadow register; a complete frame is presented
//                on dout with a one-cycle dout_valid pulse. Missing or early
//                frame_sync raises a one-cycle sync_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux16 #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  wire            clk,
  input  wire            rst_n,
  tdm_demux16_if.slave   tdm_if
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] C_SLOT_LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] C_SLOT_ONE  = SEL_W'(1);

  state_t             state_q,      state_d;
  logic [SEL_W-1:0]   slot_q,       slot_d;
  // The last slot's bit goes straight from din into dout, so the shadow only
  // needs to hold slots 0..WIDTH-2.
  logic [WIDTH-2:0]   shadow_q,     shadow_d;
  logic [WIDTH-1:0]   dout_q,       dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               sync_err_q,   sync_err_d;

  // State, slot counter, shadow, output word and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state logic: slot routing, frame completion and framing checks.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    if (tdm_if.en) begin
      case (state_q)
        ST_IDLE: begin
          // Wait for a marked slot 0; unmarked bits are silently dropped.
          if (tdm_if.frame_sync) begin
            shadow_d[0] = tdm_if.din;
            slot_d      = C_SLOT_ONE;
            state_d     = ST_RECV;
          end
        end

        ST_RECV: begin
          if (slot_q == '0) begin
            // Frame boundary: sync must be present or framing is lost.
            if (tdm_if.frame_sync) begin
              shadow_d[0] = tdm_if.din;
              slot_d      = C_SLOT_ONE;
            end else begin
              sync_err_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else if (tdm_if.frame_sync) begin
            // Early sync: abandon the partial word and restart at slot 0.
            sync_err_d  = 1'b1;
            shadow_d[0] = tdm_if.din;
            slot_d      = C_SLOT_ONE;
          end else if (slot_q == C_SLOT_LAST) begin
            dout_d       = {tdm_if.din, shadow_q};
            dout_valid_d = 1'b1;
            slot_d       = '0;
          end else begin
            shadow_d[slot_q] = tdm_if.din;
            slot_d           = slot_q + C_SLOT_ONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  assign tdm_if.dout       = dout_q;
  assign tdm_if.dout_valid = dout_valid_q;
  assign tdm_if.slot       = slot_q;
  assign tdm_if.sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux16
//  Description : Directed testbench for tdm_demux16: a table of back-to-back
//                frames plus hand-written stall, early-sync, lost-sync and
//                asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux16;
  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  tdm_demux16_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) tif ();

  tdm_demux16 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tdm_if (tif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_dout;
  } frame_vec_t;

  frame_vec_t vecs [4];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one clock worth of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic en, input logic fs, input logic d);
    tif.en         = en;
    tif.frame_sync = fs;
    tif.din        = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Send a full frame (sync on slot 0), counting pulses seen after each edge.
  task automatic send_frame(input logic [15:0] w, output int nv, output int ne, output int vcyc);
    nv = 0; ne = 0; vcyc = -1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k == 0), w[k]);
      if (tif.dout_valid) begin nv++; vcyc = cyc; end
      if (tif.sync_err) ne++;
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp, input int nv, input int ne);
    chk({name, "_valid_now"}, 32'(tif.dout_valid), 32'd1);
    chk({name, "_dout"},      32'(tif.dout),       32'(exp));
    chk({name, "_slot"},      32'(tif.slot),       32'd0);
    chk({name, "_valid_cnt"}, 32'(nv),             32'd1);
    chk({name, "_err_cnt"},   32'(ne),             32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv, ne, vcyc, prev_vcyc;
    logic [15:0] w;

    vecs[0] = '{word: 16'h3f0a, exp_dout: 16'h3f0a};
    vecs[1] = '{word: 16'ha5c3, exp_dout: 16'ha5c3};
    vecs[2] = '{word: 16'h0001, exp_dout: 16'h0001};
    vecs[3] = '{word: 16'h8000, exp_dout: 16'h8000};

    // Reset state
    rst_n = 1'b0;
    tif.en = 1'b0; tif.frame_sync = 1'b0; tif.din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  32'(tif.dout),       32'd0);
    chk("rst_slot",  32'(tif.slot),       32'd0);
    chk("rst_valid", 32'(tif.dout_valid), 32'd0);
    chk("rst_err",   32'(tif.sync_err),   32'd0);
    #2 rst_n = 1'b1;

    // Idle ignores unmarked bits without error
    nv = 0; ne = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1);
      if (tif.dout_valid) nv++;
      if (tif.sync_err) ne++;
    end
    chk("idle_slot",  32'(tif.slot), 32'd0);
    chk("idle_err",   32'(ne),       32'd0);
    chk("idle_valid", 32'(nv),       32'd0);

    // Back-to-back frames from the table
    prev_vcyc = -1;
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].word, nv, ne, vcyc);
      check_frame($sformatf("tbl%0d", i), vecs[i].exp_dout, nv, ne);
      if (i > 0) chk($sformatf("tbl%0d_gap", i), 32'(vcyc - prev_vcyc), 32'd16);
      prev_vcyc = vcyc;
    end

    // Stalls after slots 2 and 9, with a stray frame_sync while en=0
    w = 16'h0055; nv = 0; ne = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k == 0), w[k]);
      if (tif.dout_valid) nv++;
      if (tif.sync_err) ne++;
      if (k == 2 || k == 9) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 1'b1, ~w[k]);
          chk($sformatf("stall%0d_%0d_slot", k, s),  32'(tif.slot),       32'(k + 1));
          chk($sformatf("stall%0d_%0d_valid", k, s), 32'(tif.dout_valid), 32'd0);
          chk($sformatf("stall%0d_%0d_dout", k, s),  32'(tif.dout),       32'h8000);
          if (tif.sync_err) ne++;
        end
      end
    end
    check_frame("stall", 16'h0055, nv, ne);

    // Early sync at slot 7, followed by a full 0x1234 frame
    for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b1);
    chk("early_pre_slot", 32'(tif.slot), 32'd7);
    w = 16'h1234;
    step(1'b1, 1'b1, w[0]);
    chk("early_err",   32'(tif.sync_err),   32'd1);
    chk("early_valid", 32'(tif.dout_valid), 32'd0);
    chk("early_dout",  32'(tif.dout),       32'h0055);
    chk("early_slot",  32'(tif.slot),       32'd1);
    nv = 0; ne = 0;
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 1'b0, w[k]);
      if (tif.dout_valid) nv++;
      if (tif.sync_err) ne++;
    end
    check_frame("early", 16'h1234, nv, ne);

    // Lost sync after a complete frame
    send_frame(16'hffff, nv, ne, vcyc);
    check_frame("lost_pre", 16'hffff, nv, ne);
    step(1'b1, 1'b0, 1'b0);
    chk("lost_err",   32'(tif.sync_err),   32'd1);
    chk("lost_valid", 32'(tif.dout_valid), 32'd0);
    chk("lost_dout",  32'(tif.dout),       32'hffff);
    chk("lost_slot",  32'(tif.slot),       32'd0);
    ne = 0; nv = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, k[0]);
      if (tif.sync_err) ne++;
      if (tif.dout_valid) nv++;
    end
    chk("lost_idle_err",   32'(ne),       32'd0);
    chk("lost_idle_valid", 32'(nv),       32'd0);
    chk("lost_idle_slot",  32'(tif.slot), 32'd0);
    chk("lost_idle_dout",  32'(tif.dout), 32'hffff);

    // Asynchronous reset mid-frame at slot 10
    for (int k = 0; k < 10; k++) step(1'b1, (k == 0), 1'b1);
    chk("arst_pre_slot", 32'(tif.slot), 32'd10);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dout",  32'(tif.dout),       32'd0);
    chk("arst_slot",  32'(tif.slot),       32'd0);
    chk("arst_valid", 32'(tif.dout_valid), 32'd0);
    #2 rst_n = 1'b1;
    send_frame(16'h8001, nv, ne, vcyc);
    check_frame("arst_post", 16'h8001, nv, ne);

    step(1'b0, 1'b0, 1'b0);
    chk("final_valid_drop", 32'(tif.dout_valid), 32'd0);
    chk("final_dout_hold",  32'(tif.dout),       32'h8001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
